lift_ctrl: RTL and testbench

- Three-floor lift controller FSM. Latches hall/car call requests, moves the car one floor at a time on slowref ticks, and runs a door-open dwell.
- Produces floorno, which directly feeds the seven-segment floor-number display stage, plus motor and door indications.
- All state changes except request latching happen only on slowref ticks.

---
 rtl/lift_pkg.sv | 25 ++
 rtl/lift_req_reg.sv | 53 +++++
 rtl/lift_ctrl.sv | 126 ++++++++++++
 tb/tb_lift_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and constants for the three-floor lift controller.
package lift_pkg;

   typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDn, StDoor} state_e;

   localparam int unsigned NFLOORS = 3;

   localparam logic [1:0] FL_G = 2'd0;
   localparam logic [1:0] FL_1 = 2'd1;
   localparam logic [1:0] FL_2 = 2'd2;

   localparam logic DIR_DN = 1'b0;
   localparam logic DIR_UP = 1'b1;

   // Door at the current floor first, then sweep; a two-sided tie follows dir.
   function automatic state_e pick_next(input logic here, input logic above,
                                        input logic below, input logic dir);
      if (here) return StDoor;
      if (above && below) return (dir == DIR_UP) ? StMoveUp : StMoveDn;
      if (above) return StMoveUp;
      if (below) return StMoveDn;
      return StIdle;
   endfunction

endpackage

// File: rtl/lift_req_reg.sv
// Latched call requests with door-restart suppression and above/below flags
// for the floor the controller is evaluating.
module lift_req_reg
   import lift_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NFLOORS-1:0] call_req,
   input  logic [1:0]         floor,
   input  logic               in_door,
   input  logic               door_entry,
   output logic [NFLOORS-1:0] pending,
   output logic               restart,
   output logic               here,
   output logic               above,
   output logic               below
);

   logic [NFLOORS-1:0] pend_q, pend_d;
   logic [NFLOORS-1:0] floor_oh, mask_above, mask_below;

   always_comb begin
      floor_oh   = '0;
      mask_above = '0;
      mask_below = '0;
      for (int i = 0; i < NFLOORS; i++) begin
         floor_oh[i]   = (floor == 2'(i));
         mask_above[i] = (2'(i) > floor);
         mask_below[i] = (2'(i) < floor);
      end
   end

   always_comb begin
      restart = in_door & |(call_req & floor_oh);
      here    = |(pend_q & floor_oh);
      above   = |(pend_q & mask_above);
      below   = |(pend_q & mask_below);
   end

   // A call for the open-door floor never latches; clear beats set.
   always_comb begin
      pend_d = (pend_q | (call_req & ~({NFLOORS{in_door}} & floor_oh)))
               & ~({NFLOORS{door_entry}} & floor_oh);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend_q <= '0;
      else       pend_q <= pend_d;
   end

   assign pending = pend_q;

endmodule

// File: rtl/lift_ctrl.sv
// Three-floor lift controller: sweeps toward latched calls one floor at a
// time on slowref ticks and holds the door open for a fixed dwell.
module lift_ctrl
   import lift_pkg::*;
#(
   parameter int unsigned MOVE_TICKS = 2,
   parameter int unsigned DOOR_TICKS = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               slowref,
   input  logic [NFLOORS-1:0] call_req,
   output logic [1:0]         floorno,
   output logic [NFLOORS-1:0] pending,
   output logic               mot_up,
   output logic               mot_dn,
   output logic               door_open
);

   localparam int unsigned MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
   localparam int unsigned DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
   localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_TICKS - 1);
   localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);

   state_e        state_q, state_d;
   logic [1:0]    floor_q, floor_d;
   logic [MW-1:0] mcnt_q, mcnt_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          dir_q;
   logic          arrive, at_bound, door_entry;
   logic          restart, here, above, below;

   lift_req_reg u_req (
      .clk        (clk),
      .reset      (reset),
      .call_req   (call_req),
      .floor      (floor_d),
      .in_door    (state_q == StDoor),
      .door_entry (door_entry),
      .pending    (pending),
      .restart    (restart),
      .here       (here),
      .above      (above),
      .below      (below)
   );

   // Travel timing kept apart from state choice: the request flags are
   // evaluated at floor_d, so this block must not depend on them.
   always_comb begin
      floor_d  = floor_q;
      mcnt_d   = mcnt_q;
      arrive   = 1'b0;
      at_bound = ((state_q == StMoveUp) && (floor_q == FL_2)) ||
                 ((state_q == StMoveDn) && (floor_q == FL_G));
      if (slowref && ((state_q == StMoveUp) || (state_q == StMoveDn))) begin
         if (at_bound) begin
            mcnt_d = '0;
         end else if (mcnt_q == MOVE_LAST) begin
            mcnt_d  = '0;
            arrive  = 1'b1;
            floor_d = (state_q == StMoveUp) ? floor_q + 2'd1 : floor_q - 2'd1;
         end else begin
            mcnt_d = mcnt_q + MW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         StIdle: begin
            if (slowref) state_d = pick_next(here, above, below, dir_q);
         end
         StMoveUp: begin
            if (slowref && at_bound) state_d = StIdle;
            else if (arrive)         state_d = pick_next(here, above, below, DIR_UP);
         end
         StMoveDn: begin
            if (slowref && at_bound) state_d = StIdle;
            else if (arrive)         state_d = pick_next(here, above, below, DIR_DN);
         end
         StDoor: begin
            if (restart) begin
               dcnt_d = '0;
            end else if (slowref) begin
               if (dcnt_q == DOOR_LAST) begin
                  dcnt_d  = '0;
                  state_d = pick_next(1'b0, above, below, dir_q);
               end else begin
                  dcnt_d = dcnt_q + DW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign door_entry = (state_d == StDoor) && (state_q != StDoor);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         floor_q   <= FL_G;
         mcnt_q    <= '0;
         dcnt_q    <= '0;
         dir_q     <= DIR_UP;
         mot_up    <= 1'b0;
         mot_dn    <= 1'b0;
         door_open <= 1'b0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         mcnt_q    <= mcnt_d;
         dcnt_q    <= dcnt_d;
         if ((state_d == StMoveUp) && (state_q != StMoveUp)) dir_q <= DIR_UP;
         if ((state_d == StMoveDn) && (state_q != StMoveDn)) dir_q <= DIR_DN;
         mot_up    <= (state_d == StMoveUp);
         mot_dn    <= (state_d == StMoveDn);
         door_open <= (state_d == StDoor);
      end
   end

   assign floorno = floor_q;

endmodule

// File: tb/tb_lift_ctrl.sv
// Directed bench for lift_ctrl: expectations queued per step, popped and
// checked against {floorno, pending, mot_up, mot_dn, door_open}.
`timescale 1ns/1ps
module tb_lift_ctrl;

   logic       clk, reset, slowref;
   logic [2:0] call_req;
   logic [1:0] floorno;
   logic [2:0] pending;
   logic       mot_up, mot_dn, door_open;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];

   lift_ctrl #(.MOVE_TICKS(2), .DOOR_TICKS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .slowref   (slowref),
      .call_req  (call_req),
      .floorno   (floorno),
      .pending   (pending),
      .mot_up    (mot_up),
      .mot_dn    (mot_dn),
      .door_open (door_open)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [1:0] fl, input logic [2:0] p,
                           input logic u, input logic d, input logic o);
      exp_t e;
      e.tag = tag;
      e.val = {fl, p, u, d, o};
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [7:0] obs;
      e   = sb.pop_front();
      obs = {floorno, pending, mot_up, mot_dn, door_open};
      n_cmp++;
      assert (obs === e.val) else begin
         n_bad++;
         $error("FAIL %s: observed fl=%0d pend=%b up/dn/door=%b, required fl=%0d pend=%b up/dn/door=%b",
                e.tag, obs[7:6], obs[5:3], obs[2:0], e.val[7:6], e.val[5:3], e.val[2:0]);
      end
   endtask

   // One slowref pulse per 4 clks; returns on the negedge after the tick edge.
   task automatic tick();
      repeat (3) @(negedge clk);
      slowref = 1'b1;
      @(negedge clk);
      slowref = 1'b0;
   endtask

   task automatic call(input logic [2:0] v);
      @(negedge clk);
      call_req = v;
      @(negedge clk);
      call_req = '0;
   endtask

   task automatic now_chk(input string tag, input logic [1:0] fl, input logic [2:0] p,
                          input logic u, input logic d, input logic o);
      push_exp(tag, fl, p, u, d, o);
      check_out();
   endtask

   task automatic tick_chk(input string tag, input logic [1:0] fl, input logic [2:0] p,
                           input logic u, input logic d, input logic o);
      push_exp(tag, fl, p, u, d, o);
      tick();
      check_out();
   endtask

   initial begin
      reset = 1'b1; slowref = 1'b0; call_req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      now_chk("reset", 2'd0, 3'b000, 0, 0, 0);

      // Call at own floor: door opens with no motor pulse.
      call(3'b001);
      now_chk("own_pend", 2'd0, 3'b001, 0, 0, 0);
      tick_chk("own_door", 2'd0, 3'b000, 0, 0, 1);
      tick_chk("own_dw1", 2'd0, 3'b000, 0, 0, 1);
      tick_chk("own_dw2", 2'd0, 3'b000, 0, 0, 1);
      tick_chk("own_idle", 2'd0, 3'b000, 0, 0, 0);

      // No slowref for 50 clks: nothing but the latch moves.
      call(3'b100);
      repeat (50) @(negedge clk);
      now_chk("hold50", 2'd0, 3'b100, 0, 0, 0);

      // 0 -> 2 trip, passing floor 1.
      tick_chk("up_go", 2'd0, 3'b100, 1, 0, 0);
      tick_chk("up_t1", 2'd0, 3'b100, 1, 0, 0);
      tick_chk("up_f1", 2'd1, 3'b100, 1, 0, 0);
      tick_chk("up_t3", 2'd1, 3'b100, 1, 0, 0);
      tick_chk("up_f2", 2'd2, 3'b000, 0, 0, 1);
      tick_chk("f2_dw1", 2'd2, 3'b000, 0, 0, 1);
      tick_chk("f2_dw2", 2'd2, 3'b000, 0, 0, 1);
      tick_chk("f2_idle", 2'd2, 3'b000, 0, 0, 0);

      // Down to floor 1, then restart the dwell with a same-floor call.
      call(3'b010);
      now_chk("dn_pend", 2'd2, 3'b010, 0, 0, 0);
      tick_chk("dn_go", 2'd2, 3'b010, 0, 1, 0);
      tick_chk("dn_t1", 2'd2, 3'b010, 0, 1, 0);
      tick_chk("dn_f1", 2'd1, 3'b000, 0, 0, 1);
      tick_chk("f1_dw1", 2'd1, 3'b000, 0, 0, 1);
      call(3'b010);
      now_chk("restart", 2'd1, 3'b000, 0, 0, 1);
      tick_chk("rs_dw1", 2'd1, 3'b000, 0, 0, 1);
      tick_chk("rs_dw2", 2'd1, 3'b000, 0, 0, 1);
      tick_chk("rs_idle", 2'd1, 3'b000, 0, 0, 0);

      // Tie at floor 1 after a downward move: serve 0 first, then 2.
      call(3'b101);
      now_chk("tie_pend", 2'd1, 3'b101, 0, 0, 0);
      tick_chk("tie_dn", 2'd1, 3'b101, 0, 1, 0);
      tick_chk("tie_t1", 2'd1, 3'b101, 0, 1, 0);
      tick_chk("tie_f0", 2'd0, 3'b100, 0, 0, 1);
      tick_chk("tie_dw1", 2'd0, 3'b100, 0, 0, 1);
      tick_chk("tie_dw2", 2'd0, 3'b100, 0, 0, 1);
      tick_chk("rev_up", 2'd0, 3'b100, 1, 0, 0);
      tick_chk("rev_t1", 2'd0, 3'b100, 1, 0, 0);
      tick_chk("rev_f1", 2'd1, 3'b100, 1, 0, 0);
      tick_chk("rev_t3", 2'd1, 3'b100, 1, 0, 0);
      tick_chk("rev_f2", 2'd2, 3'b000, 0, 0, 1);

      // Reset during the dwell returns to floor 0.
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      now_chk("rst_dwell", 2'd0, 3'b000, 0, 0, 0);

      // Intermediate stop picked up while travelling.
      call(3'b100);
      tick_chk("mid_go", 2'd0, 3'b100, 1, 0, 0);
      tick_chk("mid_t1", 2'd0, 3'b100, 1, 0, 0);
      call(3'b010);
      now_chk("mid_pend", 2'd0, 3'b110, 1, 0, 0);
      tick_chk("mid_f1", 2'd1, 3'b100, 0, 0, 1);
      tick_chk("mid_dw1", 2'd1, 3'b100, 0, 0, 1);
      tick_chk("mid_dw2", 2'd1, 3'b100, 0, 0, 1);
      tick_chk("mid_resume", 2'd1, 3'b100, 1, 0, 0);

      // Asynchronous reset mid-MOVE_UP at floor 1, checked before any clk edge.
      #2 reset = 1'b1;
      #1 now_chk("rst_async", 2'd0, 3'b000, 0, 0, 0);
      @(negedge clk); reset = 1'b0;
      tick_chk("rst_stay", 2'd0, 3'b000, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
